// File: rtl/l1_coherence_unit_pkg.sv
// Shared coherence types: MESI state, bus transfer width, request encodings.
package l1_coherence_unit_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned BLOCK_WORDS = 2;
  localparam int unsigned XFER_W      = WORD_W * BLOCK_WORDS;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [XFER_W-1:0] transfer_width_t;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_READ    = 2'd1,
    REQ_READX   = 2'd2,
    REQ_UPGRADE = 2'd3
  } req_type_t;

  // Latched operation of the request FSM; EVICT comes from its own strobe.
  typedef enum logic [1:0] {
    OP_EVICT   = 2'd0,
    OP_READX   = 2'd1,
    OP_READ    = 2'd2,
    OP_UPGRADE = 2'd3
  } req_op_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/l1_snoop_responder.sv
// Snoop FSM: tag lookup, registered snoop response, state update and dirty-line supply.
// Build option: CC_SUPPLY_FROM_SHARED_EN lets S-state lines report a snoop hit.
module l1_snoop_responder
  import l1_coherence_unit_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  input  logic              dwait,
  input  logic              snp_valid,
  input  mesi_t             snp_state,
  output logic              ccsnoophit,
  output logic              ccIsPresent,
  output logic              ccdirty,
  output logic              ccsnoopdone,
  output logic [ADDR_W-1:0] snp_addr,
  output logic              snp_upd,
  output mesi_t             snp_nstate,
  output logic              idle_c,
  output logic              supply_load_c,
  output logic              supply_hold_c
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_SUPPLY} snp_state_t;

  snp_state_t        state_q, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic              hit_n, present_n, dirty_n, done_n, upd_n;
  mesi_t             nstate_n;
  logic              line_owned, line_hit;

  assign line_owned = snp_valid && (snp_state == MESI_M || snp_state == MESI_E);
`ifdef CC_SUPPLY_FROM_SHARED_EN
  assign line_hit   = line_owned || (snp_valid && snp_state == MESI_S);
`else
  assign line_hit   = line_owned;
`endif

  assign idle_c        = (state_q == S_IDLE);
  assign supply_load_c = (state_q == S_RESP) && ccsnoophit;
  assign supply_hold_c = (state_q == S_SUPPLY) && dwait;

  always_comb begin
    state_n   = state_q;
    addr_n    = snp_addr;
    hit_n     = ccsnoophit;
    present_n = ccIsPresent;
    dirty_n   = ccdirty;
    done_n    = 1'b0;
    upd_n     = 1'b0;
    nstate_n  = snp_nstate;
    unique case (state_q)
      S_IDLE: begin
        addr_n = ccsnoopaddr;
        if (ccwait) state_n = S_LOOKUP;
      end
      S_LOOKUP: begin
        // Bus withdrew the snoop before the tag answered: abandon quietly.
        if (!ccwait) begin
          state_n = S_IDLE;
        end else begin
          state_n   = S_RESP;
          present_n = snp_valid;
          dirty_n   = snp_valid && (snp_state == MESI_M);
          hit_n     = line_hit;
          done_n    = 1'b1;
          if (ccinv) begin
            upd_n    = 1'b1;
            nstate_n = MESI_I;
          end else if (line_owned) begin
            upd_n    = 1'b1;
            nstate_n = MESI_S;
          end
        end
      end
      S_RESP:   state_n = ccsnoophit ? S_SUPPLY : S_IDLE;
      S_SUPPLY: if (!dwait) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (state_n == S_IDLE) begin
      hit_n     = 1'b0;
      present_n = 1'b0;
      dirty_n   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      snp_addr    <= '0;
      ccsnoophit  <= 1'b0;
      ccIsPresent <= 1'b0;
      ccdirty     <= 1'b0;
      ccsnoopdone <= 1'b0;
      snp_upd     <= 1'b0;
      snp_nstate  <= MESI_I;
    end else begin
      state_q     <= state_n;
      snp_addr    <= addr_n;
      ccsnoophit  <= hit_n;
      ccIsPresent <= present_n;
      ccdirty     <= dirty_n;
      ccsnoopdone <= done_n;
      snp_upd     <= upd_n;
      snp_nstate  <= nstate_n;
    end
  end

endmodule

// File: rtl/l1_coherence_unit.sv
// L1 coherence unit: request FSM toward the bus plus the snoop responder.
// Build option: CC_SUPPLY_FROM_SHARED_EN (see l1_snoop_responder) enables S-state supply.
module l1_coherence_unit
  import l1_coherence_unit_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  req_type_t         req_type,
  input  logic              evict,
  input  logic [ADDR_W-1:0] req_addr,
  input  transfer_width_t   req_wdata,
  output logic              req_done,
  output transfer_width_t   req_rdata,
  output logic              req_excl,
  output logic              dREN,
  output logic              dWEN,
  output logic              ccwrite,
  output logic [ADDR_W-1:0] daddr,
  output transfer_width_t   dstore,
  input  logic              dwait,
  input  transfer_width_t   dload,
  input  logic              ccexclusive,
  input  logic              ccwait,
  input  logic              ccinv,
  input  logic [ADDR_W-1:0] ccsnoopaddr,
  output logic              ccsnoophit,
  output logic              ccIsPresent,
  output logic              ccdirty,
  output logic              ccsnoopdone,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_valid,
  input  mesi_t             snp_state,
  output logic              snp_upd,
  output mesi_t             snp_nstate
);

  localparam int unsigned LINE_W = BLOCK_SIZE * WORD_W;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DONE} req_state_t;

  req_state_t        state_q, state_n;
  req_op_t           op_q, op_n;
  logic [ADDR_W-1:0] addr_q, addr_n, daddr_n;
  logic [LINE_W-1:0] wdata_q, wdata_n;
  transfer_width_t   rdata_n, dstore_n;
  logic              excl_n, done_n, dren_n, dwen_n, ccwrite_n;
  logic              snoop_idle_c, supply_load_c, supply_hold_c, upgrade_lost_c;

  l1_snoop_responder u_snoop (
    .CLK           (CLK),
    .nRST          (nRST),
    .ccwait        (ccwait),
    .ccinv         (ccinv),
    .ccsnoopaddr   (ccsnoopaddr),
    .dwait         (dwait),
    .snp_valid     (snp_valid),
    .snp_state     (snp_state),
    .ccsnoophit    (ccsnoophit),
    .ccIsPresent   (ccIsPresent),
    .ccdirty       (ccdirty),
    .ccsnoopdone   (ccsnoopdone),
    .snp_addr      (snp_addr),
    .snp_upd       (snp_upd),
    .snp_nstate    (snp_nstate),
    .idle_c        (snoop_idle_c),
    .supply_load_c (supply_load_c),
    .supply_hold_c (supply_hold_c)
  );

  // Another cache invalidated our S copy: the upgrade must now fetch the line.
  assign upgrade_lost_c = (op_q == OP_UPGRADE) && snp_upd && (snp_nstate == MESI_I) &&
                          (line_addr(snp_addr) == line_addr(addr_q));

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = req_rdata;
    excl_n  = req_excl;
    unique case (state_q)
      R_IDLE: begin
        if (evict) begin
          if (snoop_idle_c) begin
            state_n = R_REQ;
            op_n    = OP_EVICT;
            addr_n  = req_addr;
            wdata_n = req_wdata;
          end
        end else if (req_type != REQ_NONE) begin
          state_n = R_REQ;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          unique case (req_type)
            REQ_READX: op_n = OP_READX;
            REQ_READ:  op_n = OP_READ;
            default:   op_n = OP_UPGRADE;
          endcase
        end
      end
      R_REQ: begin
        if (!dwait) begin
          state_n = R_DONE;
          rdata_n = dload;
          excl_n  = ccexclusive;
        end else if (upgrade_lost_c) begin
          op_n = OP_READX;
        end
      end
      R_DONE:  state_n = R_IDLE;
      default: state_n = R_IDLE;
    endcase

    done_n    = (state_n == R_DONE);
    dren_n    = (state_n == R_REQ) && (op_n == OP_READ || op_n == OP_READX);
    dwen_n    = (state_n == R_REQ) && (op_n == OP_EVICT);
    ccwrite_n = (state_n == R_REQ) && (op_n == OP_READX || op_n == OP_UPGRADE);
    daddr_n   = (state_n == R_REQ) ? line_addr(addr_n) : '0;

    // A snoop supply owns dstore; otherwise it carries eviction data.
    if (supply_load_c)      dstore_n = req_wdata;
    else if (supply_hold_c) dstore_n = dstore;
    else if (dwen_n)        dstore_n = wdata_n;
    else                    dstore_n = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= R_IDLE;
      op_q      <= OP_EVICT;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_rdata <= '0;
      req_excl  <= 1'b0;
      req_done  <= 1'b0;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      ccwrite   <= 1'b0;
      daddr     <= '0;
      dstore    <= '0;
    end else begin
      state_q   <= state_n;
      op_q      <= op_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      req_rdata <= rdata_n;
      req_excl  <= excl_n;
      req_done  <= done_n;
      dREN      <= dren_n;
      dWEN      <= dwen_n;
      ccwrite   <= ccwrite_n;
      daddr     <= daddr_n;
      dstore    <= dstore_n;
    end
  end

endmodule
